// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader: command ops, RV32I
// opcodes and funct3 values, and the loader state type.
package instr_encoder_loader_pkg;

  typedef enum logic [3:0] {
    CmdAddi = 4'd0,
    CmdXori = 4'd1,
    CmdOri  = 4'd2,
    CmdAndi = 4'd3,
    CmdAdd  = 4'd4,
    CmdXor  = 4'd5,
    CmdOr   = 4'd6,
    CmdAnd  = 4'd7,
    CmdSw   = 4'd8,
    CmdBeq  = 4'd9,
    CmdBne  = 4'd10
  } cmd_op_e;

  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeOpReg  = 7'b0110011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;

  localparam logic [2:0] F3Add = 3'b000;
  localparam logic [2:0] F3Xor = 3'b100;
  localparam logic [2:0] F3Or  = 3'b110;
  localparam logic [2:0] F3And = 3'b111;
  localparam logic [2:0] F3Sw  = 3'b010;
  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic command fields -> 32-bit RV32I word.
// illegal flags unknown ops and branch offsets outside -1024..1023 words.
module instr_encode
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0] alu_f3;

  // Pick the ALU funct3 shared by the I-type and R-type forms.
  always_comb begin
    alu_f3 = F3Add;
    case (op)
      CmdAddi, CmdAdd: alu_f3 = F3Add;
      CmdXori, CmdXor: alu_f3 = F3Xor;
      CmdOri,  CmdOr:  alu_f3 = F3Or;
      CmdAndi, CmdAnd: alu_f3 = F3And;
      default:         alu_f3 = F3Add;
    endcase
  end

  // Assemble the instruction word for the selected format.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      CmdAddi, CmdXori, CmdOri, CmdAndi: begin
        word = {imm, rs1, alu_f3, rd, OpcodeOpImm};
      end
      CmdAdd, CmdXor, CmdOr, CmdAnd: begin
        word = {7'b0000000, rs2, rs1, alu_f3, rd, OpcodeOpReg};
      end
      CmdSw: begin
        word = {imm[11:5], rs2, rs1, F3Sw, imm[4:0], OpcodeStore};
      end
      CmdBeq, CmdBne: begin
        // Byte offset b = {imm[10:0], 2'b00}: b[12]=imm[10], b[11]=imm[9],
        // b[10:5]=imm[8:3], b[4:1]={imm[2:0], 0}.
        word = {imm[10], imm[8:3], rs2, rs1, (op == CmdBeq) ? F3Beq : F3Bne,
                imm[2:0], 1'b0, imm[9], OpcodeBranch};
        // Offset must survive the shift into a 13-bit signed byte offset.
        illegal = imm[11] ^ imm[10];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic commands over valid/ready, encodes them
// and writes consecutive instruction-memory words starting at BASE.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned AW   = 5,
  parameter int unsigned BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [11:0]   cmd_imm,
  input  logic          cmd_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] BaseAddr = AW'(BASE);
  localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   count_q, count_d;
  logic          last_q, last_d;

  logic [31:0]   enc_word;
  logic          enc_illegal;

  instr_encode u_encode (
    .op      (cmd_op),
    .rd      (cmd_rd),
    .rs1     (cmd_rs1),
    .rs2     (cmd_rs2),
    .imm     (cmd_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // State and datapath registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= BaseAddr;
      wdata_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and Moore-style outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    last_d    = last_q;
    cmd_ready = 1'b0;
    imem_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      StIdle, StDone, StErr: begin
        done = (state_q == StDone);
        err  = (state_q == StErr);
        if (start) begin
          state_d = StLoad;
          addr_d  = BaseAddr;
          count_d = '0;
        end
      end
      StLoad: begin
        cmd_ready = 1'b1;
        busy      = 1'b1;
        if (cmd_valid) begin
          if (enc_illegal) begin
            state_d = StErr;
          end else begin
            wdata_d = enc_word;
            last_d  = cmd_last;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        busy = 1'b1;
        // A reset landing on the write cycle must not reach memory.
        imem_we = ~rst;
        count_d = count_q + 1'b1;
        if (last_q) begin
          state_d = StDone;
        end else if (addr_q == LastAddr) begin
          state_d = StErr;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed vectors plus randomized programs scored
// against a transaction-level model of the loader.
module tb_instr_encoder_loader;

  localparam int AW    = 4;
  localparam int BASE  = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, start2;
  logic          cmd_valid, cmd_last;
  logic [3:0]    cmd_op;
  logic [4:0]    cmd_rd, cmd_rs1, cmd_rs2;
  logic [11:0]   cmd_imm;
  logic          cmd_ready, imem_we, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          ready2, we2, busy2, done2, err2;
  logic [1:0]    addr2;
  logic [31:0]   wdata2;
  logic [2:0]    count2;

  instr_encoder_loader #(.AW(AW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder_loader #(.AW(2), .BASE(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cmd_valid(cmd_valid), .cmd_ready(ready2),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last), .imem_we(we2), .imem_addr(addr2),
    .imem_wdata(wdata2), .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] word;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [33:0] q2[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          m_addr, m_count, m_end;  // m_end: 0 running, 1 done, 2 err

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sext12(input int v);
    return (v >= 2048) ? v - 4096 : v;
  endfunction

  function automatic bit model_legal(input int op, input int imm);
    if (op > 10) return 1'b0;
    if (op >= 9) return (sext12(imm) >= -1024) && (sext12(imm) <= 1023);
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_word(input int op, input int rd, input int rs1,
                                             input int rs2, input int imm);
    int          f3tab[4] = '{0, 4, 6, 7};
    logic [31:0] b, w;
    b = 32'(sext12(imm) * 4);
    w = 32'((rs2 << 20) | (rs1 << 15));
    if (op < 4) w = 32'((imm << 20) | (rs1 << 15) | (f3tab[op] << 12) | (rd << 7) | 'h13);
    else if (op < 8) w = w | 32'((f3tab[op - 4] << 12) | (rd << 7) | 'h33);
    else if (op == 8) w = w | 32'(((imm >> 5) << 25) | (2 << 12) | ((imm % 32) << 7) | 'h23);
    else w = w | (32'(b[12]) << 31) | (((b >> 5) % 64) << 25) | 32'((op - 9) << 12)
               | (((b >> 1) % 16) << 8) | (32'(b[11]) << 7) | 32'h63;
    return w;
  endfunction

  // Every write must match the oldest expected write, one cycle after its handshake.
  always @(negedge clk) begin
    if (imem_we) begin
      check("ready_in_write", 32'(cmd_ready), 32'd0);
      check("busy_in_write", 32'(busy), 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.addr));
        check("write_data", imem_wdata, e.word);
        check("write_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
    if (we2) q2.push_back({addr2, wdata2});
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'(BASE));
    check({tag, "_wdata"}, imem_wdata, 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_addr = BASE; m_count = 0; m_end = 0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err), 32'd0);
    check("start_count", 32'(count), 32'd0);
    check("start_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Present one command; has_lit pins the expected word to a hand-computed value.
  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm,
                      input bit last, input bit has_lit, input logic [31:0] lit);
    bit got = 1'b0;
    cmd_op = 4'(op); cmd_rd = 5'(rd); cmd_rs1 = 5'(rs1); cmd_rs2 = 5'(rs2);
    cmd_imm = 12'(imm); cmd_last = last; cmd_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        if (model_legal(op, imm)) begin
          exp_q.push_back('{addr: m_addr,
                            word: has_lit ? lit : model_word(op, rd, rs1, rs2, imm),
                            cyc: cyc});
          m_count++;
          if (last) m_end = 1;
          else if (m_addr == DEPTH - 1) m_end = 2;
          else m_addr++;
        end else begin
          m_end = 2;
        end
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: cmd_ready never high, expected within 20 cycles");
      m_end = 3;
    end
  endtask

  task automatic wait_end(input string tag);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || err) break;
    end
    check({tag, "_done"}, 32'(done), 32'(m_end == 1));
    check({tag, "_err"}, 32'(err), 32'(m_end == 2));
    check({tag, "_count"}, 32'(count), 32'(m_count));
    check({tag, "_addr"}, 32'(imem_addr), 32'(m_addr));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, op, imm, gap;
    bit got;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    // Idle must not accept commands without start.
    cmd_valid = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    do_start();
    send(0, 1, 0, 0, 5, 1'b1, 1'b1, 32'h00500093);
    wait_end("addi");

    do_start();
    send(4, 3, 1, 2, 0, 1'b0, 1'b1, 32'h002081B3);
    // start across WRITE and LOAD must be ignored.
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    send(8, 0, 1, 2, 8, 1'b1, 1'b1, 32'h0020A423);
    wait_end("add_sw");

    do_start();
    send(9, 0, 1, 2, 12'hFFE, 1'b0, 1'b1, 32'hFE208CE3);
    send(10, 0, 1, 2, 12'hFFE, 1'b0, 1'b1, 32'hFE209CE3);
    send(9, 0, 3, 4, 12'hC00, 1'b0, 1'b0, 32'h0);   // -1024 words, legal edge
    send(10, 0, 5, 6, 12'h3FF, 1'b1, 1'b0, 32'h0);  // +1023 words, legal edge
    wait_end("branch");

    do_start();
    send(15, 1, 2, 3, 7, 1'b0, 1'b0, 32'h0);
    wait_end("illegal_op");
    do_start();
    send(0, 1, 0, 0, 1, 1'b0, 1'b0, 32'h0);
    send(9, 0, 1, 2, 12'h400, 1'b1, 1'b0, 32'h0);
    wait_end("beq_range_hi");
    do_start();
    send(10, 0, 1, 2, 12'hBFF, 1'b1, 1'b0, 32'h0);
    wait_end("bne_range_lo");

    for (int p = 0; p < 30; p++) begin
      do_start();
      len = $urandom_range(1, 14);
      for (int i = 0; i < len && m_end == 0; i++) begin
        op = ($urandom_range(0, 19) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
        imm = $urandom_range(0, 4095);
        if (op >= 9 && $urandom_range(0, 9) != 0) imm = (imm % 2048) + ((imm & 1024) << 1);
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm,
             i == len - 1, 1'b0, 32'h0);
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
      end
      wait_end("random");
    end

    // Reset landing on the write cycle.
    do_start();
    cmd_op = 4'd0; cmd_rd = 5'd2; cmd_rs1 = 5'd1; cmd_rs2 = 5'd0; cmd_imm = 12'd9;
    cmd_last = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    check("rst_test_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_write_we", 32'(imem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst_abort");
    cmd_valid = 1'b1;
    @(negedge clk);
    check("rst_idle_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    // Four-word memory overflows on the fourth non-last write.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_op = 4'd0; cmd_rd = 5'(i + 1); cmd_rs1 = 5'(i); cmd_rs2 = 5'd0;
      cmd_imm = 12'(i * 3); cmd_last = 1'b0; cmd_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = ready2;
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      check("ovf_handshake", 32'(got), 32'd1);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (err2) break;
    end
    check("ovf_err", 32'(err2), 32'd1);
    check("ovf_done", 32'(done2), 32'd0);
    check("ovf_count", 32'(count2), 32'd4);
    check("ovf_ready", 32'(ready2), 32'd0);
    check("ovf_writes", 32'(q2.size()), 32'd4);
    for (int i = 0; i < 4 && i < q2.size(); i++) begin
      check("ovf_addr", 32'(q2[i][33:32]), 32'(i));
      check("ovf_data", q2[i][31:0], model_word(0, i + 1, i, 0, i * 3));
    end
    repeat (4) @(negedge clk);
    check("ovf_no_fifth", 32'(q2.size()), 32'd4);
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    check("ovf_restart_err", 32'(err2), 32'd0);
    check("ovf_restart_count", 32'(count2), 32'd0);
    check("ovf_restart_busy", 32'(busy2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
